// File: rtl/xphy_pkg.sv
// Shared definitions for the XPHY training-bus responder: FSM state encoding,
// register index constants and the fixed read-data values.
package xphy_pkg;

    typedef enum logic [2:0] {
        XPHY_IDLE     = 3'd0,
        XPHY_ACCESS   = 3'd1,
        XPHY_DRP_WAIT = 3'd2,
        XPHY_ACK      = 3'd3,
        XPHY_RELEASE  = 3'd4
    } xphy_state_t;

    localparam logic [2:0]  XPHY_REG_CTRL   = 3'd0;
    localparam logic [2:0]  XPHY_REG_STATUS = 3'd1;

    localparam logic [15:0] XPHY_RD_MISS          = 16'hFFFF;
    localparam logic [15:0] XPHY_DRP_TIMEOUT_DATA = 16'hDEAD;

    // An IPIF access hits the bank only for the matching MMD and indices 0..7.
    function automatic logic xphy_ipif_hit(input logic [20:0] addr, input logic [4:0] mmd);
        return (addr[20:16] == mmd) && (addr[15:3] == 13'd0);
    endfunction

endpackage

// File: rtl/xphy_train_regs.sv
// Local register bank of the training responder.
//   reg0 : control, bit15 is a sticky DRP-timeout flag (set by hardware,
//          cleared by writing 1), bits 14:0 read/write
//   reg1 : {8'h00, core_status}, read-only
//   reg2..reg7 : scratch read/write
module xphy_train_regs
    import xphy_pkg::*;
(
    input  logic        dclk,
    input  logic        rst_n,
    input  logic [2:0]  i_idx,
    input  logic        i_we,
    input  logic [15:0] i_wdata,
    input  logic [7:0]  i_core_status,
    input  logic        i_sticky_set,
    output logic [15:0] o_rdata,
    output logic [15:0] o_ctrl
);

    logic [15:0]      r_ctrl;
    logic [5:0][15:0] w_scratch;
    logic [2:0]       w_sidx;
    logic             w_ctrl_we;

    assign w_ctrl_we = i_we && (i_idx == XPHY_REG_CTRL);
    assign w_sidx    = i_idx - 3'd2;
    assign o_ctrl    = r_ctrl;

    // Control register; hardware set of the sticky flag takes priority over a clear.
    always_ff @(posedge dclk) begin
        if (!rst_n) begin
            r_ctrl <= 16'h0000;
        end else begin
            if (w_ctrl_we) begin
                r_ctrl[14:0] <= i_wdata[14:0];
            end
            if (i_sticky_set) begin
                r_ctrl[15] <= 1'b1;
            end else if (w_ctrl_we && i_wdata[15]) begin
                r_ctrl[15] <= 1'b0;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 2; gi < 8; gi++) begin : g_scratch
            logic [15:0] r_val;

            // One scratch register per index.
            always_ff @(posedge dclk) begin
                if (!rst_n) begin
                    r_val <= 16'h0000;
                end else if (i_we && (i_idx == 3'(gi))) begin
                    r_val <= i_wdata;
                end
            end

            assign w_scratch[gi-2] = r_val;
        end
    endgenerate

    // Read mux over the bank.
    always_comb begin
        o_rdata = 16'h0000;
        case (i_idx)
            XPHY_REG_CTRL:   o_rdata = r_ctrl;
            XPHY_REG_STATUS: o_rdata = {8'h00, i_core_status};
            default:         o_rdata = w_scratch[w_sidx];
        endcase
    end

endmodule

// File: rtl/xphy_training_resp.sv
// XPHY training-bus responder: accepts one request per cs assertion, serves the
// local register bank after a fixed latency and issues exactly one ack.
// Optional DRP forwarding is compiled in with XPHY_TRAIN_DRP_EN; without it
// DRP-space reads return 0 and DRP-space writes are dropped.
module xphy_training_resp
    import xphy_pkg::*;
#(
    parameter logic [4:0] C_MMD         = 5'd1,
    parameter int         C_LATENCY     = 2,
    parameter int         C_DRP_TIMEOUT = 255
) (
    input  logic        dclk,
    input  logic        rst_n,
    input  logic        training_enable,
    input  logic [20:0] training_addr,
    input  logic        training_rnw,
    input  logic [15:0] training_wrdata,
    input  logic        training_ipif_cs,
    input  logic        training_drp_cs,
    output logic [15:0] training_rddata,
    output logic        training_rdack,
    output logic        training_wrack,
    input  logic [7:0]  core_status,
    output logic [15:0] ctrl_out,
    output logic        busy
`ifdef XPHY_TRAIN_DRP_EN
    ,
    output logic        drp_den,
    output logic        drp_dwe,
    output logic [15:0] drp_daddr,
    output logic [15:0] drp_di,
    input  logic [15:0] drp_do,
    input  logic        drp_drdy
`endif
);

    // An out-of-range configuration never accepts a request, so a mis-sized
    // counter can never leave the bus hanging mid-transaction.
    localparam bit LP_PARAMS_OK = (C_LATENCY >= 1) && (C_LATENCY <= 15) &&
                                  (C_DRP_TIMEOUT >= 1) && (C_DRP_TIMEOUT <= 65535);

    xphy_state_t r_state;
    logic [3:0]  r_cnt;
    logic [20:0] r_addr;
    logic        r_rnw;
    logic [15:0] r_wrdata;
    logic        r_is_ipif;
    logic [15:0] r_rddata;
    logic        r_rdack;
    logic        r_wrack;
    logic        r_busy;

    logic        w_req;
    logic        w_hit;
    logic        w_commit;
    logic        w_reg_we;
    logic        w_sticky_set;
    logic [15:0] w_reg_rdata;
    logic [15:0] w_rd_value;

`ifdef XPHY_TRAIN_DRP_EN
    logic        r_den;
    logic        r_dwe;
    logic [15:0] r_daddr;
    logic [15:0] r_di;
    logic [15:0] r_tcnt;
    logic        w_drp_timeout;

    assign drp_den   = r_den;
    assign drp_dwe   = r_dwe;
    assign drp_daddr = r_daddr;
    assign drp_di    = r_di;

    // drdy wins over a timeout that expires on the same edge.
    assign w_drp_timeout = (r_state == XPHY_DRP_WAIT) && !drp_drdy &&
                           (r_tcnt == 16'(C_DRP_TIMEOUT));
    assign w_sticky_set  = w_drp_timeout;
`else
    assign w_sticky_set  = 1'b0;
`endif

    assign w_req    = LP_PARAMS_OK && training_enable && (training_ipif_cs || training_drp_cs);
    assign w_hit    = xphy_ipif_hit(r_addr, C_MMD);
    assign w_commit = (r_state == XPHY_ACCESS) && (r_cnt == 4'd0);
    assign w_reg_we = w_commit && !r_rnw && r_is_ipif && w_hit;

    // Without DRP forwarding a DRP-space read returns 0.
    assign w_rd_value = r_is_ipif ? (w_hit ? w_reg_rdata : XPHY_RD_MISS) : 16'h0000;

    assign training_rddata = r_rddata;
    assign training_rdack  = r_rdack;
    assign training_wrack  = r_wrack;
    assign busy            = r_busy;

    xphy_train_regs u_regs (
        .dclk          (dclk),
        .rst_n         (rst_n),
        .i_idx         (r_addr[2:0]),
        .i_we          (w_reg_we),
        .i_wdata       (r_wrdata),
        .i_core_status (core_status),
        .i_sticky_set  (w_sticky_set),
        .o_rdata       (w_reg_rdata),
        .o_ctrl        (ctrl_out)
    );

    // Request/ack state machine with registered acks, read data and DRP strobes.
    always_ff @(posedge dclk) begin
        if (!rst_n) begin
            r_state   <= XPHY_IDLE;
            r_cnt     <= 4'd0;
            r_addr    <= 21'd0;
            r_rnw     <= 1'b0;
            r_wrdata  <= 16'h0000;
            r_is_ipif <= 1'b0;
            r_rddata  <= 16'h0000;
            r_rdack   <= 1'b0;
            r_wrack   <= 1'b0;
            r_busy    <= 1'b0;
`ifdef XPHY_TRAIN_DRP_EN
            r_den     <= 1'b0;
            r_dwe     <= 1'b0;
            r_daddr   <= 16'h0000;
            r_di      <= 16'h0000;
            r_tcnt    <= 16'd0;
`endif
        end else begin
            r_rdack <= 1'b0;
            r_wrack <= 1'b0;
`ifdef XPHY_TRAIN_DRP_EN
            r_den   <= 1'b0;
`endif
            case (r_state)
                XPHY_IDLE: begin
                    if (w_req) begin
                        r_addr    <= training_addr;
                        r_rnw     <= training_rnw;
                        r_wrdata  <= training_wrdata;
                        r_is_ipif <= training_ipif_cs;
                        r_busy    <= 1'b1;
`ifdef XPHY_TRAIN_DRP_EN
                        if (!training_ipif_cs) begin
                            r_den   <= 1'b1;
                            r_dwe   <= ~training_rnw;
                            r_daddr <= training_addr[15:0];
                            r_di    <= training_wrdata;
                            r_tcnt  <= 16'd1;
                            r_state <= XPHY_DRP_WAIT;
                        end else
`endif
                        begin
                            r_cnt   <= 4'(C_LATENCY - 1);
                            r_state <= XPHY_ACCESS;
                        end
                    end
                end

                XPHY_ACCESS: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= XPHY_ACK;
                        if (r_rnw) begin
                            r_rdack  <= 1'b1;
                            r_rddata <= w_rd_value;
                        end else begin
                            r_wrack  <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end

`ifdef XPHY_TRAIN_DRP_EN
                XPHY_DRP_WAIT: begin
                    if (drp_drdy || w_drp_timeout) begin
                        r_state <= XPHY_ACK;
                        if (r_rnw) begin
                            r_rdack  <= 1'b1;
                            r_rddata <= drp_drdy ? drp_do : XPHY_DRP_TIMEOUT_DATA;
                        end else begin
                            r_wrack  <= 1'b1;
                        end
                    end else begin
                        r_tcnt <= r_tcnt + 16'd1;
                    end
                end
`endif

                XPHY_ACK: begin
                    r_state <= XPHY_RELEASE;
                end

                XPHY_RELEASE: begin
                    if (!training_ipif_cs && !training_drp_cs) begin
                        r_state <= XPHY_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= XPHY_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xphy_training_resp.sv
// Directed bench for xphy_training_resp (default parameters: MMD 1, latency 2,
// DRP timeout 255). DRP-forwarding checks are compiled with XPHY_TRAIN_DRP_EN.
module tb_xphy_training_resp;

    localparam int LAT = 2;

    logic        dclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        training_enable = 1'b0;
    logic [20:0] training_addr = '0;
    logic        training_rnw = 1'b0;
    logic [15:0] training_wrdata = '0;
    logic        training_ipif_cs = 1'b0;
    logic        training_drp_cs = 1'b0;
    logic [15:0] training_rddata;
    logic        training_rdack;
    logic        training_wrack;
    logic [7:0]  core_status = 8'h00;
    logic [15:0] ctrl_out;
    logic        busy;
`ifdef XPHY_TRAIN_DRP_EN
    logic        drp_den;
    logic        drp_dwe;
    logic [15:0] drp_daddr;
    logic [15:0] drp_di;
    logic [15:0] drp_do = 16'hBEEF;
    logic        drp_drdy = 1'b0;
    int          drp_delay = 5;
    int          drp_cnt = -1;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 dclk = ~dclk;

    xphy_training_resp dut (
        .dclk             (dclk),
        .rst_n            (rst_n),
        .training_enable  (training_enable),
        .training_addr    (training_addr),
        .training_rnw     (training_rnw),
        .training_wrdata  (training_wrdata),
        .training_ipif_cs (training_ipif_cs),
        .training_drp_cs  (training_drp_cs),
        .training_rddata  (training_rddata),
        .training_rdack   (training_rdack),
        .training_wrack   (training_wrack),
        .core_status      (core_status),
        .ctrl_out         (ctrl_out),
        .busy             (busy)
`ifdef XPHY_TRAIN_DRP_EN
        ,
        .drp_den          (drp_den),
        .drp_dwe          (drp_dwe),
        .drp_daddr        (drp_daddr),
        .drp_di           (drp_di),
        .drp_do           (drp_do),
        .drp_drdy         (drp_drdy)
`endif
    );

`ifdef XPHY_TRAIN_DRP_EN
    // DRP target model: drdy pulses drp_delay cycles after den; negative delay never answers.
    initial begin
        forever begin
            @(negedge dclk);
            drp_drdy = 1'b0;
            if (drp_den) begin
                drp_cnt = drp_delay;
            end else if (drp_cnt > 0) begin
                drp_cnt = drp_cnt - 1;
                if (drp_cnt == 0) begin
                    drp_drdy = 1'b1;
                    drp_cnt  = -1;
                end
            end
        end
    end
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // One bus transaction. Inputs other than cs are scrambled right after the
    // sampling edge; cs is held at least 'hold' cycles and until the ack.
    task automatic xact(input logic ipif, input logic rnw, input logic [20:0] addr,
                        input logic [15:0] wd, input int hold, input logic drop_en,
                        output logic [15:0] rd, output int lat, output int nrd,
                        output int nwr, output int busy_err);
        bit done;
        done = 0; rd = 16'h0; lat = -1; nrd = 0; nwr = 0; busy_err = 0;
        @(negedge dclk);
        training_enable  = 1'b1;
        training_ipif_cs = ipif;
        training_drp_cs  = !ipif;
        training_addr    = addr;
        training_rnw     = rnw;
        training_wrdata  = wd;
        for (int cyc = 1; cyc <= 400 && !done; cyc++) begin
            @(negedge dclk);
            if (cyc == 1) begin
                training_addr   = ~addr;
                training_rnw    = ~rnw;
                training_wrdata = ~wd;
                if (drop_en) training_enable = 1'b0;
`ifdef XPHY_TRAIN_DRP_EN
                if (!ipif) begin
                    check("drp_den", 32'(drp_den), 32'd1);
                    check("drp_daddr", 32'(drp_daddr), 32'(addr[15:0]));
                    check("drp_dwe", 32'(drp_dwe), 32'(!rnw));
                    check("drp_di", 32'(drp_di), 32'(wd));
                end
`endif
            end
            if (training_rdack) begin
                nrd++;
                rd = training_rddata;
                if (lat < 0) lat = cyc - 1;
            end
            if (training_wrack) begin
                nwr++;
                if (lat < 0) lat = cyc - 1;
            end
            if (training_ipif_cs || training_drp_cs) begin
                if (!busy) busy_err++;
                if (lat >= 0 && cyc >= hold) begin
                    training_ipif_cs = 1'b0;
                    training_drp_cs  = 1'b0;
                end
            end else if (!busy) begin
                done = 1;
            end
        end
        if (!done) check("xact_bound", 32'd0, 32'd1);
        training_enable  = 1'b0;
        training_ipif_cs = 1'b0;
        training_drp_cs  = 1'b0;
    endtask

    task automatic wr(input string tag, input logic [20:0] addr, input logic [15:0] wd);
        logic [15:0] rd;
        int lat, nrd, nwr, be;
        xact(1'b1, 1'b0, addr, wd, 0, 1'b0, rd, lat, nrd, nwr, be);
        check({tag, "_wrack"}, 32'(nwr), 32'd1);
        check({tag, "_rdack"}, 32'(nrd), 32'd0);
        check({tag, "_lat"}, 32'(lat), 32'(LAT));
    endtask

    task automatic rd_chk(input string tag, input logic [20:0] addr, input logic [15:0] exp);
        logic [15:0] rd;
        int lat, nrd, nwr, be;
        xact(1'b1, 1'b1, addr, 16'h0000, 0, 1'b0, rd, lat, nrd, nwr, be);
        check({tag, "_data"}, 32'(rd), 32'(exp));
        check({tag, "_rdack"}, 32'(nrd), 32'd1);
        check({tag, "_wrack"}, 32'(nwr), 32'd0);
    endtask

    initial begin
        logic [15:0] rd;
        int lat, nrd, nwr, be, stray;

        repeat (3) @(negedge dclk);
        check("rst_rddata", 32'(training_rddata), 32'h0);
        check("rst_rdack", 32'(training_rdack), 32'h0);
        check("rst_wrack", 32'(training_wrack), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_ctrl", 32'(ctrl_out), 32'h0);
`ifdef XPHY_TRAIN_DRP_EN
        check("rst_den", 32'(drp_den), 32'h0);
        check("rst_daddr", 32'(drp_daddr), 32'h0);
`endif
        rst_n = 1'b1;

        // Scratch write/read-back with latency
        wr("wr_scratch2", 21'h10002, 16'h1234);
        xact(1'b1, 1'b1, 21'h10002, 16'h0, 0, 1'b0, rd, lat, nrd, nwr, be);
        check("rd_scratch2_data", 32'(rd), 32'h1234);
        check("rd_scratch2_lat", 32'(lat), 32'(LAT));
        check("rd_scratch2_rdack", 32'(nrd), 32'd1);
        check("rd_held_after_ack", 32'(training_rddata), 32'h1234);

        // Status mirror is read-only
        core_status = 8'h01;
        rd_chk("rd_status", 21'h10001, 16'h0001);
        wr("wr_status", 21'h10001, 16'hFFFF);
        rd_chk("rd_status_again", 21'h10001, 16'h0001);

        // Misses: wrong MMD and out-of-range register
        rd_chk("rd_bad_mmd", 21'h20002, 16'hFFFF);
        wr("wr_bad_mmd", 21'h20002, 16'h5555);
        rd_chk("rd_after_miss", 21'h10002, 16'h1234);
        rd_chk("rd_bad_reg", 21'h10008, 16'hFFFF);
        wr("wr_bad_reg", 21'h1000A, 16'h6666);
        rd_chk("rd_scratch2_kept", 21'h10002, 16'h1234);

        // Control: bit15 is not writable as 1 while the flag is clear
        wr("wr_ctrl", 21'h10000, 16'hFABC);
        check("ctrl_out_written", 32'(ctrl_out), 32'h7ABC);
        rd_chk("rd_ctrl", 21'h10000, 16'h7ABC);

        // cs held for 10 cycles: one ack, busy throughout
        xact(1'b1, 1'b1, 21'h10002, 16'h0, 10, 1'b0, rd, lat, nrd, nwr, be);
        check("hold_acks", 32'(nrd + nwr), 32'd1);
        check("hold_busy_err", 32'(be), 32'd0);
        check("hold_data", 32'(rd), 32'h1234);

        // Enable dropped after sampling does not abort
        xact(1'b1, 1'b0, 21'h10007, 16'hA5C3, 0, 1'b1, rd, lat, nrd, nwr, be);
        check("drop_en_wrack", 32'(nwr), 32'd1);
        rd_chk("rd_scratch7", 21'h10007, 16'hA5C3);

`ifdef XPHY_TRAIN_DRP_EN
        // DRP read answered after 5 cycles
        drp_delay = 5;
        xact(1'b0, 1'b1, 21'h00123, 16'h0, 0, 1'b0, rd, lat, nrd, nwr, be);
        check("drp_rd_data", 32'(rd), 32'hBEEF);
        check("drp_rd_rdack", 32'(nrd), 32'd1);
        check("drp_rd_lat", 32'(lat), 32'd6);
        // DRP read never answered
        drp_delay = -1;
        xact(1'b0, 1'b1, 21'h00456, 16'h0, 0, 1'b0, rd, lat, nrd, nwr, be);
        check("drp_to_data", 32'(rd), 32'hDEAD);
        check("drp_to_rdack", 32'(nrd), 32'd1);
        check("drp_to_lat", 32'(lat), 32'd255);
        check("drp_to_flag", 32'(ctrl_out), 32'hFABC);
        wr("wr_ctrl_clear", 21'h10000, 16'h8000);
        check("ctrl_flag_cleared", 32'(ctrl_out), 32'h0000);
`else
        // DRP space without forwarding: read 0, write dropped
        xact(1'b0, 1'b1, 21'h10002, 16'h0, 0, 1'b0, rd, lat, nrd, nwr, be);
        check("drp_rd_data", 32'(rd), 32'h0000);
        check("drp_rd_rdack", 32'(nrd), 32'd1);
        check("drp_rd_lat", 32'(lat), 32'(LAT));
        xact(1'b0, 1'b0, 21'h10002, 16'hAAAA, 0, 1'b0, rd, lat, nrd, nwr, be);
        check("drp_wr_wrack", 32'(nwr), 32'd1);
        rd_chk("rd_after_drp_wr", 21'h10002, 16'h1234);
`endif

        // Reset mid-transaction
        wr("wr_ctrl_pre_rst", 21'h10000, 16'h0042);
        check("ctrl_pre_rst", 32'(ctrl_out), 32'h0042);
`ifdef XPHY_TRAIN_DRP_EN
        drp_delay = -1;
`endif
        stray = 0;
        @(negedge dclk);
        training_enable  = 1'b1;
        training_rnw     = 1'b1;
        training_addr    = 21'h10002;
`ifdef XPHY_TRAIN_DRP_EN
        training_drp_cs  = 1'b1;
`else
        training_ipif_cs = 1'b1;
`endif
        @(negedge dclk);
        rst_n = 1'b0;
        @(negedge dclk);
        if (training_rdack || training_wrack) stray++;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ctrl", 32'(ctrl_out), 32'h0);
`ifdef XPHY_TRAIN_DRP_EN
        check("mid_rst_den", 32'(drp_den), 32'd0);
`endif
        rst_n            = 1'b1;
        training_enable  = 1'b0;
        training_ipif_cs = 1'b0;
        training_drp_cs  = 1'b0;
        repeat (8) begin
            @(negedge dclk);
            if (training_rdack || training_wrack) stray++;
        end
        check("mid_rst_no_ack", 32'(stray), 32'd0);
        rd_chk("rd_scratch2_rst", 21'h10002, 16'h0000);
        rd_chk("rd_scratch7_rst", 21'h10007, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
